uart_tx_arbiter: RTL and testbench

Shares one multi-byte UART frame transmitter (`pi_data`/`pi_flag`/`tx_done` pump) among several requesters, e.g. joint telemetry, status and debug sources on the robot arm controller. The arbiter picks requesters in round-robin order and latches the winning payload. It then pulses the pump's start, waits for the pump's done with a watchdog, and enforces a programmable idle gap between frames. It sits between the requesters and the UART TX pump; the pump's `pi_data` is driven from this block's held register.

---
 rtl/uart_tx_arbiter.sv | 149 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one multi-byte UART TX pump
// among NUM_REQ requesters. Latches the winning payload, pulses the pump start,
// waits for the pump done under a watchdog, then enforces an idle gap.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 120,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 100_000,
  localparam int ID_W          = $clog2(NUM_REQ)
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         pump_data,
  output logic                          pump_flag,
  input  logic                          pump_done,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [ID_W:0]    NUM_REQ_W = (ID_W + 1)'(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t                r_state;
  logic [TO_W-1:0]       r_wd_cnt;
  logic [GAP_W-1:0]      r_gap_cnt;
  logic [ID_W-1:0]       r_last_grant;
  logic [DATA_WIDTH-1:0] r_pump_data;
  logic                  r_pump_flag;
  logic [NUM_REQ-1:0]    r_req_ready;
  logic [ID_W-1:0]       r_grant_id;
  logic                  r_busy;
  logic                  r_timeout_err;

  logic [DATA_WIDTH-1:0] w_slice [NUM_REQ];
  logic [NUM_REQ-1:0]    w_winner_onehot;
  logic [ID_W-1:0]       w_winner;
  logic [ID_W:0]         w_cand;
  logic                  w_any_req;
  logic                  w_wd_fire;

  // Split the flat payload bus into one slice per requester and decode the
  // winner into the one-hot acceptance pattern.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign w_slice[gi]         = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign w_winner_onehot[gi] = (w_winner == ID_W'(gi));
  end

  assign w_any_req = |req_valid;
  assign w_wd_fire = (r_wd_cnt == TO_LAST);

  // Round-robin pick: scan from last_grant+NUM_REQ down to last_grant+1 so the
  // closest requester after the previous winner is the last one to overwrite.
  always_comb begin
    w_winner = r_last_grant;
    w_cand   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = {1'b0, r_last_grant} + (ID_W + 1)'(k);
      if (w_cand >= NUM_REQ_W) begin
        w_cand = w_cand - NUM_REQ_W;
      end
      if (req_valid[w_cand[ID_W-1:0]]) begin
        w_winner = w_cand[ID_W-1:0];
      end
    end
  end

  // Control FSM with all outputs registered; pump_data only changes on a grant.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state       <= S_IDLE;
      r_wd_cnt      <= '0;
      r_gap_cnt     <= '0;
      r_last_grant  <= ID_W'(NUM_REQ - 1);
      r_pump_data   <= '0;
      r_pump_flag   <= 1'b0;
      r_req_ready   <= '0;
      r_grant_id    <= '0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_pump_flag   <= 1'b0;
      r_req_ready   <= '0;
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_pump_data  <= w_slice[w_winner];
            r_grant_id   <= w_winner;
            r_last_grant <= w_winner;
            r_pump_flag  <= 1'b1;
            r_req_ready  <= w_winner_onehot;
            r_wd_cnt     <= '0;
            r_busy       <= 1'b1;
            r_state      <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (pump_done || w_wd_fire) begin
            // done takes precedence over a watchdog expiring on the same edge
            r_timeout_err <= !pump_done;
            r_gap_cnt     <= '0;
            if (GAP_CYCLES == 0) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_GAP;
            end
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign pump_data   = r_pump_data;
  assign pump_flag   = r_pump_flag;
  assign grant_id    = r_grant_id;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: table-driven arbitration vectors, directed multi-cycle
// sequences (round robin gap, watchdog, stray done, async reset) and a
// randomized run against a timestamp-based reference model.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int DW = 120;
  localparam int G  = 3;
  localparam int T  = 50;
  localparam logic [NR-1:0] ONE = {{(NR-1){1'b0}}, 1'b1};

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]   req_ready;
  logic [DW-1:0]   pump_data;
  logic            pump_flag;
  logic            pump_done = 1'b0;
  logic [1:0]      grant_id;
  logic            busy;
  logic            timeout_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)
  ) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .pump_data(pump_data), .pump_flag(pump_flag),
    .pump_done(pump_done), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct {
    logic [NR-1:0] valid;
    int            delay;
    int            exp_id;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] slice_of(input int id);
    return req_data[id*DW +: DW];
  endfunction

  task automatic fill_all();
    for (int r = 0; r < NR; r++) req_data[r*DW +: DW] = rand_word();
  endtask

  task automatic wait_flag(output int n, input string tag);
    n = 0;
    while (pump_flag !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL %s wait_flag: actual=no pump_flag required=pump_flag within 100 cycles", tag);
    end
  endtask

  task automatic do_reset();
    req_valid = '0;
    pump_done = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One complete frame: grant, acceptance checks, pump done after d cycles,
  // then the idle gap length and pump_data hold.
  task automatic do_frame(input logic [NR-1:0] v, input int d, input int exp_id, input string tag);
    int n;
    logic [DW-1:0] exp_data;
    req_valid = v;
    wait_flag(n, tag);
    exp_data = slice_of(exp_id);
    check({tag, " grant_id"}, 256'(grant_id), 256'(exp_id));
    check({tag, " req_ready"}, 256'(req_ready), 256'(ONE << exp_id));
    check({tag, " pump_data"}, 256'(pump_data), 256'(exp_data));
    check({tag, " busy"}, 256'(busy), 256'(1));
    $display("frame %s: grant_id=%0d req_ready=%b pump_data=%h", tag, grant_id, req_ready, pump_data);
    req_valid = '0;
    @(negedge clk);
    check({tag, " pulse_fall"}, 256'({pump_flag, req_ready}), 256'(0));
    fill_all();
    repeat (d - 2) @(negedge clk);
    check({tag, " data_hold"}, 256'(pump_data), 256'(exp_data));
    pump_done = 1'b1;
    @(negedge clk);
    pump_done = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, " gap_busy"}, 256'(busy), 256'(1));
    @(negedge clk);
    check({tag, " idle_busy"}, 256'(busy), 256'(0));
    check({tag, " data_after"}, 256'(pump_data), 256'(exp_data));
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout: actual=still running required=finished");
    $fatal(1, "global time limit");
  end

  initial begin
    int n;
    int n2;
    bit seen;
    int dl [3];
    bit ee [3];
    // reference model state (timestamps in edge numbers)
    int e, m_last, m_start, m_idle_at, w;
    bit m_in;
    logic e_flag, e_busy, e_err;
    logic [NR-1:0] e_ready;
    logic [1:0] e_gid;
    logic [DW-1:0] e_data;

    tbl[0] = '{4'b0100, 20, 2};
    tbl[1] = '{4'b1111, 10, 3};
    tbl[2] = '{4'b1111, 5, 0};
    tbl[3] = '{4'b0011, 7, 1};
    tbl[4] = '{4'b0011, 2, 0};
    tbl[5] = '{4'b1000, 12, 3};
    tbl[6] = '{4'b0110, 3, 1};
    tbl[7] = '{4'b1001, 8, 3};
    tbl[8] = '{4'b0001, 4, 0};
    tbl[9] = '{4'b1110, 6, 1};

    // ---- reset values ----
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst pump_flag", 256'(pump_flag), 256'(0));
    check("rst req_ready", 256'(req_ready), 256'(0));
    check("rst grant_id", 256'(grant_id), 256'(0));
    check("rst pump_data", 256'(pump_data), 256'(0));
    check("rst busy", 256'(busy), 256'(0));
    check("rst timeout_err", 256'(timeout_err), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // ---- table-driven arbitration vectors ----
    for (int i = 0; i < 10; i++) begin
      fill_all();
      if (i == 0) req_data[2*DW +: DW] = {15{8'hA5}};
      do_frame(tbl[i].valid, tbl[i].delay, tbl[i].exp_id, $sformatf("vec%0d", i));
    end

    // ---- round robin with all requesters held, done after 10 cycles ----
    do_reset();
    fill_all();
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_flag(n, "rr");
      check($sformatf("rr%0d grant_id", i), 256'(grant_id), 256'(i % NR));
      check($sformatf("rr%0d req_ready", i), 256'(req_ready), 256'(ONE << (i % NR)));
      $display("rr grant %0d: grant_id=%0d", i, grant_id);
      if (i == 4) req_valid = '0;
      repeat (9) @(negedge clk);
      pump_done = 1'b1;
      @(negedge clk);
      pump_done = 1'b0;
      if (i < 4) begin
        n = 0;
        while (pump_flag !== 1'b1 && n < 20) begin
          @(negedge clk);
          n++;
        end
        check($sformatf("rr%0d done_to_flag", i), 256'(n), 256'(4));
      end
    end
    repeat (3) @(negedge clk);
    check("rr final idle", 256'(busy), 256'(0));

    // ---- watchdog: pump never completes, next requester waits ----
    do_reset();
    fill_all();
    req_valid = 4'b0001;
    wait_flag(n, "wdog");
    req_valid = 4'b0010;
    n = 0;
    while (timeout_err !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wdog latency", 256'(n), 256'(T));
    $display("watchdog fired %0d cycles after pump_flag", n);
    @(negedge clk);
    check("wdog single_pulse", 256'(timeout_err), 256'(0));
    wait_flag(n2, "wdog_next");
    check("wdog next_gap", 256'(n2), 256'(3));
    check("wdog next grant_id", 256'(grant_id), 256'(1));
    req_valid = '0;
    repeat (4) @(negedge clk);
    pump_done = 1'b1;
    @(negedge clk);
    pump_done = 1'b0;
    repeat (3) @(negedge clk);
    check("wdog next idle", 256'(busy), 256'(0));

    // ---- done near the watchdog limit ----
    dl = '{49, 50, 51};
    ee = '{1'b0, 1'b0, 1'b1};
    for (int j = 0; j < 3; j++) begin
      req_valid = 4'b0001;
      wait_flag(n, "wdb");
      req_valid = '0;
      seen = 1'b0;
      repeat (dl[j] - 1) begin
        @(negedge clk);
        if (timeout_err === 1'b1) seen = 1'b1;
      end
      pump_done = 1'b1;
      @(negedge clk);
      pump_done = 1'b0;
      if (timeout_err === 1'b1) seen = 1'b1;
      repeat (3) begin
        @(negedge clk);
        if (timeout_err === 1'b1) seen = 1'b1;
      end
      check($sformatf("wdb done@%0d err", dl[j]), 256'(seen), 256'(ee[j]));
      check($sformatf("wdb done@%0d idle", dl[j]), 256'(busy), 256'(0));
      $display("done at cycle %0d: timeout_err seen=%0d", dl[j], seen);
    end

    // ---- stray done in IDLE and in GAP ----
    seen = 1'b0;
    pump_done = 1'b1;
    @(negedge clk);
    pump_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (busy !== 1'b0 || pump_flag !== 1'b0 || timeout_err !== 1'b0) seen = 1'b1;
    end
    check("stray idle", 256'(seen), 256'(0));
    req_valid = 4'b0001;
    wait_flag(n, "stray_gap");
    req_valid = '0;
    repeat (4) @(negedge clk);
    pump_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    pump_done = 1'b0;
    @(negedge clk);
    check("stray gap busy", 256'(busy), 256'(1));
    @(negedge clk);
    check("stray gap idle", 256'(busy), 256'(0));
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (pump_flag !== 1'b0 || timeout_err !== 1'b0) seen = 1'b1;
    end
    check("stray gap no_grant", 256'(seen), 256'(0));

    // ---- asynchronous reset while waiting for done ----
    do_reset();
    fill_all();
    req_valid = 4'b0100;
    wait_flag(n, "rst_mid");
    check("rst_mid first grant", 256'(grant_id), 256'(2));
    req_valid = '0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid outputs", 256'({pump_flag, req_ready, grant_id, busy, timeout_err, pump_data}), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 4'b1010;
    wait_flag(n, "rst_after");
    check("rst_after grant_id", 256'(grant_id), 256'(1));
    check("rst_after req_ready", 256'(req_ready), 256'(4'b0010));
    $display("after reset: grant_id=%0d", grant_id);
    req_valid = '0;
    pump_done = 1'b1;
    @(negedge clk);
    pump_done = 1'b0;
    repeat (4) @(negedge clk);

    // ---- randomized run against the reference model ----
    do_reset();
    m_last = NR - 1;
    m_in = 1'b0;
    m_start = 0;
    m_idle_at = -1;
    e_ready = '0;
    e_flag = 1'b0;
    e_err = 1'b0;
    e_busy = 1'b0;
    e_gid = '0;
    e_data = '0;
    for (int c = 0; c < 3000; c++) begin
      e = c;
      // stimulus for edge e
      for (int r = 0; r < NR; r++) begin
        if (((req_valid >> r) & ONE) != '0) begin
          if (((e_ready >> r) & ONE) != '0) begin
            if ($urandom_range(0, 1) == 0) req_valid = req_valid & ~(ONE << r);
          end else if ($urandom_range(0, 15) == 0) begin
            req_valid = req_valid & ~(ONE << r);
          end
        end else begin
          if ($urandom_range(0, 3) == 0) req_data[r*DW +: DW] = rand_word();
          if ($urandom_range(0, 5) == 0) req_valid = req_valid | (ONE << r);
        end
      end
      pump_done = ($urandom_range(0, 29) == 0);
      // reference model: what the outputs must be after edge e
      e_flag = 1'b0;
      e_ready = '0;
      e_err = 1'b0;
      if (m_in) begin
        if (pump_done) begin
          m_in = 1'b0;
          m_idle_at = e + G;
        end else if (e - m_start == T) begin
          e_err = 1'b1;
          m_in = 1'b0;
          m_idle_at = e + G;
        end
      end else if (e > m_idle_at && req_valid != '0) begin
        w = -1;
        for (int k = 1; k <= NR; k++) begin
          if (w < 0 && ((req_valid >> ((m_last + k) % NR)) & ONE) != '0) w = (m_last + k) % NR;
        end
        m_last = w;
        e_gid = 2'(w);
        e_data = slice_of(w);
        e_flag = 1'b1;
        e_ready = ONE << w;
        m_in = 1'b1;
        m_start = e;
        $display("random grant at edge %0d: requester %0d", e, w);
      end
      e_busy = m_in || (e < m_idle_at);
      @(negedge clk);
      check($sformatf("random edge%0d", e),
            256'({pump_flag, req_ready, grant_id, busy, timeout_err, pump_data}),
            256'({e_flag, e_ready, e_gid, e_busy, e_err, e_data}));
    end
    req_valid = '0;
    pump_done = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
